// File: rtl/rv32_div_seq.sv
// ============================================================================
//  Module      : rv32_div_seq
//  Description : Sequential radix-2 restoring divider for RV32-M DIV/DIVU/REM/REMU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic [XLEN-1:0] o_res,
  output logic            o_done,
  output logic            o_busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            rsel_q, rsel_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic            unused_f3;
  assign unused_f3 = i_f3[2];

  logic            accept, is_signed, neg1, neg2;
  logic [XLEN-1:0] mag1, mag2, q_fix, r_fix;
  logic [XLEN:0]   trial, diff;

  always_comb begin
    accept    = i_start && (state_q == S_IDLE || state_q == S_DONE);
    is_signed = ~i_f3[0];
    neg1      = is_signed & i_rs1[XLEN-1];
    neg2      = is_signed & i_rs2[XLEN-1];
    mag1      = neg1 ? -i_rs1 : i_rs1;
    mag2      = neg2 ? -i_rs2 : i_rs2;
    // Remainder shifted left with the next dividend bit entering from the quotient.
    trial     = {rem_q, quot_q[XLEN-1]};
    diff      = trial - {1'b0, dvsr_q};
    q_fix     = qneg_q ? -quot_q : quot_q;
    r_fix     = rneg_q ? -rem_q : rem_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    rsel_d  = rsel_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    done_d  = done_q;
    busy_d  = busy_q;

    case (state_q)
      S_CALC: begin
        if (diff[XLEN]) begin
          rem_d  = trial[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b0};
        end else begin
          rem_d  = diff[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b1};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = rsel_q ? r_fix : q_fix;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      default: ;
    endcase

    if (accept) begin
      rsel_d = i_f3[1];
      if (i_rs2 == '0) begin
        res_d   = i_f3[1] ? i_rs1 : '1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end else if (is_signed && i_rs1 == MIN_NEG && i_rs2 == '1) begin
        res_d   = i_f3[1] ? '0 : MIN_NEG;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end else begin
        rem_d   = '0;
        quot_d  = mag1;
        dvsr_d  = mag2;
        qneg_d  = neg1 ^ neg2;
        rneg_d  = neg1;
        cnt_d   = CNT_INIT;
        done_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = S_CALC;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      rsel_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      rsel_q  <= rsel_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_res  = res_q;
  assign o_done = done_q;
  assign o_busy = busy_q;

endmodule

`default_nettype wire
